// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port (req/gnt/rvalid)
// and the instruction hand-off to decode (valid/ready).
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output inst_valid, inst_out, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  inst_valid, inst_out, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited word fetch from instruction memory,
// in-order prefetch FIFO, redirect flush with discard of in-flight responses,
// and halt once the fetch address passes MAX_PC and everything has drained.
//
// Optional feature macro: IFU_BYPASS_EN
//   defined   -> a response arriving at an empty FIFO drives decode in the same cycle
//   undefined -> decode is always fed from the FIFO registers
//
// state | meaning
// RUN   | fetching / draining
// HALT  | fetch address past MAX_PC, FIFO empty, nothing in flight (done=1)
module instr_fetch_unit #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4,
    parameter logic [ADDR_W-1:0] MAX_PC = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic                redirect,
    instr_fetch_unit_if.master  bus,
    output logic                done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 2;

    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  disc_q, disc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  outst_rst;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] tag_mem  [DEPTH];

    logic grant, keep, push, pop, empty, bypass;

    // Handshake decode, FIFO head / bypass output mux, and all next-state values.
    always_comb begin
        grant = req_q & bus.mem_gnt;
        empty = (count_q == '0);
        keep  = bus.mem_rvalid & (disc_q == '0) & ~redirect;
`ifdef IFU_BYPASS_EN
        bypass = rst_n & empty & keep;
`else
        bypass = 1'b0;
`endif
        pop  = ~empty & bus.inst_ready & ~redirect;
        push = keep & ~(bypass & bus.inst_ready);

        bus.mem_req    = req_q;
        bus.mem_addr   = addr_q;
        bus.inst_valid = ~empty | bypass;
        bus.inst_out   = '0;
        bus.inst_pc    = '0;
        if (!empty) begin
            bus.inst_out = data_mem[rd_q];
            bus.inst_pc  = tag_mem[rd_q];
        end else if (bypass) begin
            bus.inst_out = bus.mem_rdata;
            bus.inst_pc  = resp_pc_q;
        end

        // Outstanding never goes negative: responses left over from before a
        // reset are dropped without having been counted.
        outst_d = outst_q + CNT_W'(grant);
        if (bus.mem_rvalid && outst_d != '0) outst_d = outst_d - CNT_W'(1);
        outst_rst = (bus.mem_rvalid && outst_q != '0) ? outst_q - CNT_W'(1) : outst_q;

        disc_d = disc_q;
        if (bus.mem_rvalid && disc_q != '0) disc_d = disc_q - CNT_W'(1);
        if (redirect) disc_d = outst_d;

        fetch_d = redirect ? pc_in : fetch_q + ADDR_W'(grant);

        // Kept responses are in address order from the last redirect target,
        // so the tag is just a running address.
        resp_pc_d = resp_pc_q;
        if (redirect)  resp_pc_d = pc_in;
        else if (keep) resp_pc_d = resp_pc_q + ADDR_W'(1);

        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (redirect) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (pop)  rd_d = rd_q + PTR_W'(1);
            if (push) wr_d = wr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        state_d = state_q;
        if (redirect) begin
            if (pc_in <= MAX_PC) state_d = RUN;
        end else if (state_q == RUN && fetch_q > MAX_PC && outst_q == '0 && empty) begin
            state_d = HALT;
        end

        req_d = (state_d == RUN) && (fetch_d <= MAX_PC) &&
                ((count_d + outst_d) < CNT_W'(DEPTH));
    end

    // State, counters, pointers and the registered request port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            fetch_q   <= '0;
            resp_pc_q <= '0;
            outst_q   <= '0;
            disc_q    <= outst_rst;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            fetch_q   <= fetch_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            disc_q    <= disc_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            req_q     <= req_d;
            addr_q    <= fetch_d;
        end
    end

    // FIFO storage; contents need no reset since empty masks the outputs.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem[wr_q] <= bus.mem_rdata;
            tag_mem[wr_q]  <= resp_pc_q;
        end
    end

    assign done = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] MAX_PC = 32'd17;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pc_in = '0;
    logic        done;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PC(MAX_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .redirect(redirect), .bus(bus), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic drop; } fl_t;
    typedef struct packed { logic [31:0] data; logic [31:0] pc; } fe_t;
    typedef struct packed { logic [31:0] due; logic [31:0] addr; } mq_t;

    // reference model: in-flight request list (with drop marks) and FIFO contents
    fl_t m_fl[$];
    fe_t m_ff[$];
    logic [31:0] m_fetch = '0, m_addr = '0;
    bit m_halt = 0, m_req = 0, m_live = 0;

    mq_t mq[$];
    int  cyc = 0, lat = 1;
    bit  gnt_i = 0, ready_i = 0, force_rv = 0;
    int  n_cmp = 0, n_bad = 0;

    logic [31:0] acc_pc[$], acc_dat[$], g_addr[$], v_pc[$];
    int          acc_cyc[$], g_cyc[$];

    function automatic logic [31:0] img(input logic [31:0] a);
        return 32'hC0DE_0000 | (a * 32'd7 + 32'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_pc.delete(); acc_dat.delete(); acc_cyc.delete();
        g_addr.delete(); g_cyc.delete(); v_pc.delete();
    endtask

    task automatic cycle();
        logic rv;
        logic [31:0] rd, ga, exp_out, exp_pc;
        bit g, byp, exp_valid, keep, resp_used, halt_cond, acc;
        fl_t e;
        mq_t m;
        bus.mem_gnt    = gnt_i;
        bus.inst_ready = ready_i;
        resp_used = 0;
        e = '0;
        if (force_rv) begin
            rv = 1'b1; rd = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due == 32'(cyc)) begin
            rv = 1'b1; rd = img(mq[0].addr); resp_used = 1;
        end else begin
            rv = 1'b0; rd = '0;
        end
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;
        #1;
        byp = BYP && rst_n && m_live && m_ff.size() == 0 && rv && !redirect &&
              m_fl.size() > 0 && !m_fl[0].drop;
        exp_valid = (m_ff.size() > 0) || byp;
        if (m_ff.size() > 0) begin exp_out = m_ff[0].data; exp_pc = m_ff[0].pc; end
        else if (byp)        begin exp_out = rd;           exp_pc = m_fl[0].addr; end
        else                 begin exp_out = '0;           exp_pc = '0; end
        if (m_live) begin
            chk("mem_req", 64'(bus.mem_req), 64'(m_req));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            chk("inst_valid", 64'(bus.inst_valid), 64'(exp_valid));
            chk("done", 64'(done), 64'(m_halt));
            if (exp_valid) begin
                chk("inst_out", 64'(bus.inst_out), 64'(exp_out));
                chk("inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
            end
        end
        if (rst_n && bus.inst_valid === 1'b1) v_pc.push_back(bus.inst_pc);
        if (rst_n && bus.inst_valid === 1'b1 && ready_i) begin
            acc_pc.push_back(bus.inst_pc); acc_dat.push_back(bus.inst_out); acc_cyc.push_back(cyc);
        end
        g  = rst_n && (bus.mem_req === 1'b1) && gnt_i;
        ga = bus.mem_addr;
        if (resp_used) void'(mq.pop_front());
        if (g) begin
            m.due = 32'(cyc + lat); m.addr = ga;
            mq.push_back(m);
            g_addr.push_back(ga); g_cyc.push_back(cyc);
        end
        if (!rst_n) begin
            if (rv && m_fl.size() > 0) void'(m_fl.pop_front());
            foreach (m_fl[i]) m_fl[i].drop = 1'b1;
            m_ff.delete();
            m_fetch = '0; m_halt = 0; m_req = 0; m_addr = '0; m_live = 1;
        end else if (m_live) begin
            halt_cond = !m_halt && (m_fetch > MAX_PC) && m_fl.size() == 0 && m_ff.size() == 0;
            acc  = m_req && gnt_i;
            keep = 0;
            if (rv && m_fl.size() > 0) begin
                e = m_fl.pop_front();
                keep = !e.drop && !redirect;
            end
            if (redirect) m_ff.delete();
            else begin
                if (m_ff.size() > 0 && ready_i) void'(m_ff.pop_front());
                if (keep && !(byp && ready_i)) m_ff.push_back({rd, e.addr});
            end
            if (acc) m_fl.push_back({m_addr, 1'b0});
            if (redirect) begin
                foreach (m_fl[i]) m_fl[i].drop = 1'b1;
                if (pc_in <= MAX_PC) m_halt = 0;
                m_fetch = pc_in;
            end else begin
                if (halt_cond) m_halt = 1;
                if (acc) m_fetch = m_fetch + 32'd1;
            end
            m_addr = m_fetch;
            m_req  = !m_halt && (m_fetch <= MAX_PC) && (m_ff.size() + m_fl.size() < DEPTH);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (done !== 1'b1 && guard < 300) begin cycle(); guard++; end
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] mx;
        int bad;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.inst_ready = 0;
        @(posedge clk); #1;

        // 1. reset with rvalid pulses
        rst_n = 0; force_rv = 1; gnt_i = 1; ready_i = 1;
        run(2);
        force_rv = 0; bus.mem_rvalid = 0; #1;
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst_out", 64'(bus.inst_out), 64'd0);
        chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1; lat = 1; clear_logs();
        cycle();
        chk("first_req", 64'(bus.mem_req), 64'd1);
        chk("first_addr", 64'(bus.mem_addr), 64'd0);

        // 2. streaming, L=1
        run(9);
        gnt_i = 0;
        run(5);
        chk("stream_count", 64'(acc_pc.size()), 64'd9);
        if (acc_pc.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk("stream_pc", 64'(acc_pc[k]), 64'(k));
                chk("stream_data", 64'(acc_dat[k]), 64'(img(32'(k))));
            end
            chk("stream_rate", 64'(acc_cyc[8] - acc_cyc[0]), 64'd8);
        end
        chk("hold_req", 64'(bus.mem_req), 64'd1);
        chk("hold_addr", 64'(bus.mem_addr), 64'd9);

        // 3. backpressure
        clear_logs(); gnt_i = 1; ready_i = 0;
        run(10);
        chk("bp_grants", 64'(g_addr.size()), 64'd4);
        if (g_addr.size() > 0) chk("bp_last_grant", 64'(g_addr[$]), 64'd12);
        chk("bp_req_low", 64'(bus.mem_req), 64'd0);
        chk("bp_head_pc", 64'(bus.inst_pc), 64'd9);
        chk("bp_head_data", 64'(bus.inst_out), 64'(img(32'd9)));
        bad = 0;
        foreach (v_pc[i]) if (v_pc[i] != 32'd9) bad++;
        chk("bp_stable", 64'(bad), 64'd0);
        clear_logs(); gnt_i = 0; ready_i = 1;
        run(6);
        chk("bp_release_count", 64'(acc_pc.size()), 64'd4);
        if (acc_pc.size() == 4)
            for (int k = 0; k < 4; k++) chk("bp_release_pc", 64'(acc_pc[k]), 64'(9 + k));

        // 4. redirect with two in flight plus a same-cycle response
        lat = 3; gnt_i = 1;
        run(3);
        gnt_i = 0; redirect = 1; pc_in = 32'h0A;
        chk("rd_rvalid_same_cycle", 64'(mq.size() > 0 ? mq[0].due : 0), 64'(cyc));
        cycle();
        redirect = 0; gnt_i = 1; clear_logs();
        run(14);
        chk("rd_accepts", 64'(acc_pc.size() >= 3), 64'd1);
        if (acc_pc.size() >= 3) begin
            chk("rd_first_pc", 64'(acc_pc[0]), 64'h0A);
            chk("rd_second_pc", 64'(acc_pc[1]), 64'h0B);
            chk("rd_third_pc", 64'(acc_pc[2]), 64'h0C);
        end

        // 5. halt after sequential run from 0, then redirect to 3
        redirect = 1; pc_in = 0;
        cycle();
        redirect = 0; clear_logs();
        wait_done("halt_done");
        mx = '0;
        foreach (g_addr[i]) if (g_addr[i] > mx) mx = g_addr[i];
        chk("halt_max_grant", 64'(mx), 64'd17);
        if (g_addr.size() > 0) chk("halt_last_grant", 64'(g_addr[$]), 64'd17);
        chk("halt_consumed", 64'(acc_pc.size()), 64'd18);
        if (acc_pc.size() == 18) begin
            chk("halt_first_pc", 64'(acc_pc[0]), 64'd0);
            chk("halt_last_pc", 64'(acc_pc[17]), 64'd17);
        end
        redirect = 1; pc_in = 32'd3;
        cycle();
        redirect = 0;
        chk("redir_clears_done", 64'(done), 64'd0);
        clear_logs();
        wait_done("halt_done_again");
        chk("refetch_count", 64'(acc_pc.size()), 64'd15);
        if (acc_pc.size() > 0) chk("refetch_first_pc", 64'(acc_pc[0]), 64'd3);

        // 6. latency from grant to inst_valid with L=2 and an empty FIFO
        lat = 2; redirect = 1; pc_in = 0;
        cycle();
        redirect = 0; clear_logs();
        run(8);
        if (g_addr.size() > 0 && acc_pc.size() > 0) begin
            chk("lat_grant_addr", 64'(g_addr[0]), 64'd0);
            chk("lat_first_pc", 64'(acc_pc[0]), 64'd0);
            chk("lat_cycles", 64'(acc_cyc[0] - g_cyc[0]), BYP ? 64'd2 : 64'd3);
        end else begin
            chk("lat_activity", 64'd0, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
